// File: rtl/reg_scoreboard_if.sv
// Decode/writeback handshake bundle for reg_scoreboard.
interface reg_scoreboard_if #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned TOT_WIDTH = 4,
  parameter int unsigned IDX_WIDTH = 4
);
  logic                 I_LOCK;
  logic                 I_IssueValid;
  logic                 I_Src1Use;
  logic                 I_Src2Use;
  logic [IDX_WIDTH-1:0] I_Src1Idx;
  logic [IDX_WIDTH-1:0] I_Src2Idx;
  logic                 I_DestWrite;
  logic [IDX_WIDTH-1:0] I_DestIdx;
  logic                 I_UsesCC;
  logic                 I_WBValid;
  logic [IDX_WIDTH-1:0] I_WBIdx;
  logic                 I_Flush;
  logic                 O_Stall;
  logic                 O_Issue;
  logic [NUM_REGS-1:0]  O_Busy;
  logic [TOT_WIDTH-1:0] O_InFlight;
  logic                 O_Error;

  modport master (
    output I_LOCK, I_IssueValid, I_Src1Use, I_Src2Use, I_Src1Idx, I_Src2Idx,
           I_DestWrite, I_DestIdx, I_UsesCC, I_WBValid, I_WBIdx, I_Flush,
    input  O_Stall, O_Issue, O_Busy, O_InFlight, O_Error
  );

  modport slave (
    input  I_LOCK, I_IssueValid, I_Src1Use, I_Src2Use, I_Src1Idx, I_Src2Idx,
           I_DestWrite, I_DestIdx, I_UsesCC, I_WBValid, I_WBIdx, I_Flush,
    output O_Stall, O_Issue, O_Busy, O_InFlight, O_Error
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-dependence scoreboard with saturating pending-write counters.
// Define REG_SCOREBOARD_WB_FWD_EN to let same-cycle writebacks release dependents.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned CNT_WIDTH = 2,
  parameter int unsigned TOT_WIDTH = 4
) (
  input logic              I_CLOCK,
  input logic              I_RESET,
  reg_scoreboard_if.slave  sb
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [TOT_WIDTH-1:0] TOT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
  logic [TOT_WIDTH-1:0] tot_q, tot_d;
  logic                 err_q, err_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;

  logic [CNT_WIDTH-1:0] eff_src1, eff_src2, eff_dest;
  logic [TOT_WIDTH-1:0] eff_tot;
  logic                 wb_hit, tot_dec, inc, stall_c, issue_c;

  // A writeback only retires something if the register actually has a pending write.
  assign wb_hit  = sb.I_WBValid && (cnt_q[sb.I_WBIdx] != '0);
  assign tot_dec = wb_hit && (tot_q != '0);

  // Effective counts seen by the stall check
  always_comb begin
    eff_src1 = cnt_q[sb.I_Src1Idx];
    eff_src2 = cnt_q[sb.I_Src2Idx];
    eff_dest = cnt_q[sb.I_DestIdx];
    eff_tot  = tot_q;
`ifdef REG_SCOREBOARD_WB_FWD_EN
    if (wb_hit) begin
      if (sb.I_WBIdx == sb.I_Src1Idx) eff_src1 = eff_src1 - CNT_WIDTH'(1);
      if (sb.I_WBIdx == sb.I_Src2Idx) eff_src2 = eff_src2 - CNT_WIDTH'(1);
      if (sb.I_WBIdx == sb.I_DestIdx) eff_dest = eff_dest - CNT_WIDTH'(1);
    end
    if (tot_dec) eff_tot = eff_tot - TOT_WIDTH'(1);
`endif
  end

  always_comb begin
    stall_c = sb.I_LOCK && sb.I_IssueValid &&
              ((sb.I_Src1Use   && (eff_src1 != '0))     ||
               (sb.I_Src2Use   && (eff_src2 != '0))     ||
               (sb.I_DestWrite && (eff_dest == CNT_MAX)) ||
               (sb.I_UsesCC    && (eff_tot != '0)));
    issue_c = sb.I_LOCK && sb.I_IssueValid && !stall_c;
  end

  assign inc = issue_c && sb.I_DestWrite;

  // Next-state for counters and sticky error
  always_comb begin
    cnt_d = cnt_q;
    tot_d = tot_q;
    err_d = err_q;
    if (sb.I_LOCK) begin
      if (sb.I_Flush) begin
        cnt_d = '{default: '0};
        tot_d = '0;
      end else begin
        if (inc)    cnt_d[sb.I_DestIdx] = cnt_d[sb.I_DestIdx] + CNT_WIDTH'(1);
        if (wb_hit) cnt_d[sb.I_WBIdx]   = cnt_d[sb.I_WBIdx] - CNT_WIDTH'(1);
        if (sb.I_WBValid && !wb_hit) err_d = 1'b1;
        if (inc && !tot_dec) begin
          if (tot_q == TOT_MAX) err_d = 1'b1;
          else                  tot_d = tot_q + TOT_WIDTH'(1);
        end else if (!inc && tot_dec) begin
          tot_d = tot_q - TOT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    busy_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) busy_d[i] = (cnt_d[i] != '0);
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      cnt_q  <= '{default: '0};
      tot_q  <= '0;
      err_q  <= 1'b0;
      busy_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tot_q  <= tot_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  assign sb.O_Stall    = stall_c;
  assign sb.O_Issue    = issue_c;
  assign sb.O_Busy     = busy_q;
  assign sb.O_InFlight = tot_q;
  assign sb.O_Error    = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with a per-register pending-count model.
module tb_reg_scoreboard;
`ifdef REG_SCOREBOARD_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic I_CLOCK = 1'b0;
  logic I_RESET = 1'b1;
  always #5 I_CLOCK = ~I_CLOCK;

  reg_scoreboard_if sb ();

  reg_scoreboard dut (
    .I_CLOCK (I_CLOCK),
    .I_RESET (I_RESET),
    .sb      (sb.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int pend [16];
  int total;
  bit merr;
  bit model_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_cnt(input int idx);
    int e = pend[idx];
    if (FWD && sb.I_WBValid && int'(sb.I_WBIdx) == idx && e > 0) e--;
    return e;
  endfunction

  function automatic bit m_stall();
    int et = total;
    if (!sb.I_LOCK || !sb.I_IssueValid) return 1'b0;
    if (FWD && sb.I_WBValid && pend[sb.I_WBIdx] > 0 && et > 0) et--;
    return (sb.I_Src1Use   && eff_cnt(int'(sb.I_Src1Idx)) > 0) ||
           (sb.I_Src2Use   && eff_cnt(int'(sb.I_Src2Idx)) > 0) ||
           (sb.I_DestWrite && eff_cnt(int'(sb.I_DestIdx)) == 3) ||
           (sb.I_UsesCC    && et > 0);
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b = '0;
    for (int i = 0; i < 16; i++) b[i] = (pend[i] != 0);
    return b;
  endfunction

  task automatic compare_all();
    bit s = m_stall();
    chk("stall",    32'(sb.O_Stall),    32'(s));
    chk("issue",    32'(sb.O_Issue),    32'(sb.I_LOCK && sb.I_IssueValid && !s));
    chk("busy",     32'(sb.O_Busy),     32'(m_busy()));
    chk("inflight", 32'(sb.O_InFlight), 32'(total));
    chk("error",    32'(sb.O_Error),    32'(merr));
  endtask

  task automatic model_update();
    bit issue;
    bit wb_ok;
    int inc, dec;
    if (I_RESET) begin
      foreach (pend[i]) pend[i] = 0;
      total = 0;
      merr = 1'b0;
      model_valid = 1'b1;
      return;
    end
    if (!model_valid || !sb.I_LOCK) return;
    if (sb.I_Flush) begin
      foreach (pend[i]) pend[i] = 0;
      total = 0;
      return;
    end
    issue = sb.I_IssueValid && !m_stall();
    wb_ok = sb.I_WBValid && pend[sb.I_WBIdx] > 0;
    inc = (issue && sb.I_DestWrite) ? 1 : 0;
    dec = (wb_ok && total > 0) ? 1 : 0;
    if (sb.I_WBValid && !wb_ok) merr = 1'b1;
    if (inc == 1) pend[sb.I_DestIdx]++;
    if (wb_ok) pend[sb.I_WBIdx]--;
    if (total + inc - dec > 15) merr = 1'b1;
    else total = total + inc - dec;
  endtask

  task automatic step();
    #1;
    if (model_valid) compare_all();
    model_update();
    @(posedge I_CLOCK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    sb.I_LOCK = 1'b1; sb.I_IssueValid = 1'b0;
    sb.I_Src1Use = 1'b0; sb.I_Src2Use = 1'b0; sb.I_Src1Idx = '0; sb.I_Src2Idx = '0;
    sb.I_DestWrite = 1'b0; sb.I_DestIdx = '0; sb.I_UsesCC = 1'b0;
    sb.I_WBValid = 1'b0; sb.I_WBIdx = '0; sb.I_Flush = 1'b0;
  endtask

  task automatic instr(input bit s1u, input int s1, input bit s2u, input int s2,
                       input bit dw, input int d, input bit cc);
    sb.I_IssueValid = 1'b1;
    sb.I_Src1Use = s1u; sb.I_Src1Idx = 4'(s1);
    sb.I_Src2Use = s2u; sb.I_Src2Idx = 4'(s2);
    sb.I_DestWrite = dw; sb.I_DestIdx = 4'(d); sb.I_UsesCC = cc;
  endtask

  task automatic wb(input bit v, input int idx);
    sb.I_WBValid = v; sb.I_WBIdx = 4'(idx);
  endtask

  initial begin
    idle();
    I_RESET = 1'b1;
    step(); step();
    I_RESET = 1'b0;
    chk("rst_busy", 32'(sb.O_Busy), 32'h0);
    chk("rst_inflight", 32'(sb.O_InFlight), 32'h0);
    chk("rst_error", 32'(sb.O_Error), 32'h0);

    // ADD R1 <- R2, R3
    instr(1, 2, 1, 3, 1, 1, 0); settle();
    chk("add_issue", 32'(sb.O_Issue), 32'h1);
    step();
    sb.I_IssueValid = 1'b0;
    chk("add_busy", 32'(sb.O_Busy), 32'h0002);
    chk("add_inflight", 32'(sb.O_InFlight), 32'h1);

    // SUB R5 <- R1, R0 waits on R1
    instr(1, 1, 1, 0, 1, 5, 0); settle();
    chk("raw_stall", 32'(sb.O_Stall), 32'h1);
    step(); step();
    wb(1, 1); settle();
    chk("raw_wb_issue", 32'(sb.O_Issue), 32'(FWD));
    step();
    wb(0, 0);
    if (!FWD) begin
      settle();
      chk("raw_late_issue", 32'(sb.O_Issue), 32'h1);
      step();
    end
    sb.I_IssueValid = 1'b0;
    chk("raw_busy", 32'(sb.O_Busy), 32'h0020);
    wb(1, 5); step(); wb(0, 0);
    chk("raw_drain", 32'(sb.O_InFlight), 32'h0);

    // Saturate R4
    for (int k = 0; k < 3; k++) begin
      instr(0, 0, 0, 0, 1, 4, 0); settle();
      chk("sat_issue", 32'(sb.O_Issue), 32'h1);
      step();
    end
    settle();
    chk("sat_stall", 32'(sb.O_Stall), 32'h1);
    step(); step();
    wb(1, 4); settle();
    chk("sat_wb_issue", 32'(sb.O_Issue), 32'(FWD));
    step();
    wb(0, 0);
    if (!FWD) begin
      settle();
      chk("sat_late_issue", 32'(sb.O_Issue), 32'h1);
      step();
    end
    sb.I_IssueValid = 1'b0;
    chk("sat_busy", 32'(sb.O_Busy), 32'h0010);
    chk("sat_inflight", 32'(sb.O_InFlight), 32'h3);
    repeat (3) begin wb(1, 4); step(); end
    wb(0, 0);
    chk("sat_drain", 32'(sb.O_InFlight), 32'h0);

    // BRN waits for all in-flight writes
    instr(0, 0, 0, 0, 1, 6, 0); step();
    instr(0, 0, 0, 0, 1, 7, 0); step();
    instr(0, 0, 0, 0, 0, 0, 1); settle();
    chk("brn_stall", 32'(sb.O_Stall), 32'h1);
    step();
    wb(1, 6); settle();
    chk("brn_stall_wb1", 32'(sb.O_Stall), 32'h1);
    step();
    wb(1, 7); settle();
    chk("brn_wb2_issue", 32'(sb.O_Issue), 32'(FWD));
    step();
    wb(0, 0);
    if (!FWD) begin
      settle();
      chk("brn_late_issue", 32'(sb.O_Issue), 32'h1);
      step();
    end
    sb.I_IssueValid = 1'b0;
    chk("brn_inflight", 32'(sb.O_InFlight), 32'h0);

    // Issue and writeback of R5 in the same cycle
    instr(0, 0, 0, 0, 1, 5, 0); step();
    wb(1, 5); settle();
    chk("same_issue", 32'(sb.O_Issue), 32'h1);
    step();
    wb(0, 0); sb.I_IssueValid = 1'b0;
    chk("same_busy", 32'(sb.O_Busy), 32'h0020);
    chk("same_inflight", 32'(sb.O_InFlight), 32'h1);
    wb(1, 5); step(); wb(0, 0);

    // LOCK low freezes everything
    instr(0, 0, 0, 0, 1, 1, 0); step();
    instr(1, 1, 0, 0, 0, 0, 0);
    sb.I_LOCK = 1'b0; wb(1, 1); settle();
    chk("lock_stall", 32'(sb.O_Stall), 32'h0);
    chk("lock_issue", 32'(sb.O_Issue), 32'h0);
    step();
    sb.I_LOCK = 1'b1; wb(0, 0);
    chk("lock_inflight", 32'(sb.O_InFlight), 32'h1);
    chk("lock_busy", 32'(sb.O_Busy), 32'h0002);

    // Reset while stalled releases the stall
    settle();
    chk("mid_stall", 32'(sb.O_Stall), 32'h1);
    step();
    I_RESET = 1'b1; step(); I_RESET = 1'b0;
    settle();
    chk("mid_rst_issue", 32'(sb.O_Issue), 32'h1);
    step();
    sb.I_IssueValid = 1'b0;

    // Spurious writeback, then flush keeps the error
    instr(0, 0, 0, 0, 1, 2, 0); step();
    sb.I_IssueValid = 1'b0;
    wb(1, 9); step(); wb(0, 0);
    chk("err_set", 32'(sb.O_Error), 32'h1);
    step();
    chk("err_sticky", 32'(sb.O_Error), 32'h1);
    sb.I_Flush = 1'b1; instr(0, 0, 0, 0, 1, 3, 0); wb(1, 2); step();
    sb.I_Flush = 1'b0; sb.I_IssueValid = 1'b0; wb(0, 0);
    chk("flush_busy", 32'(sb.O_Busy), 32'h0);
    chk("flush_inflight", 32'(sb.O_InFlight), 32'h0);
    chk("flush_err", 32'(sb.O_Error), 32'h1);
    I_RESET = 1'b1; step(); I_RESET = 1'b0;
    chk("rst_clears_err", 32'(sb.O_Error), 32'h0);

    // Total counter overflow
    for (int r = 0; r < 5; r++) begin
      repeat (3) begin instr(0, 0, 0, 0, 1, r, 0); step(); end
    end
    instr(0, 0, 0, 0, 1, 5, 0); step();
    sb.I_IssueValid = 1'b0;
    chk("ovf_inflight", 32'(sb.O_InFlight), 32'hF);
    chk("ovf_busy", 32'(sb.O_Busy), 32'h003F);
    chk("ovf_err", 32'(sb.O_Error), 32'h1);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
